// File: rtl/fp_bound_pkg.sv
// rtl/fp_bound_pkg.sv - ordering modes and float classification helpers for fp_bound_vec
package fp_bound_pkg;

    typedef enum logic [1:0] {
        ABS_LE = 2'd0,
        ABS_LT = 2'd1,
        SGN_LE = 2'd2,
        SGN_LT = 2'd3
    } mode_t;

    function automatic int fp_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    // Callers zero-extend the word to 64 bits; widths select the fields.
    function automatic logic is_zero(input logic [63:0] word, input int exp_w, input int man_w);
        logic [63:0] mag_mask;
        mag_mask = (64'd1 << (exp_w + man_w)) - 64'd1;
        return (word & mag_mask) == 64'd0;
    endfunction

    function automatic logic is_nan(input logic [63:0] word, input int exp_w, input int man_w);
        logic [63:0] man_mask;
        logic [63:0] exp_mask;
        man_mask = (64'd1 << man_w) - 64'd1;
        exp_mask = ((64'd1 << exp_w) - 64'd1) << man_w;
        return ((word & exp_mask) == exp_mask) && ((word & man_mask) != 64'd0);
    endfunction

    // Signed IEEE-style order from magnitude flags; +0 and -0 are equal.
    function automatic logic sgn_order(input logic mag_lt, input logic mag_eq,
                                       input logic a_sign, input logic b_sign,
                                       input logic a_zero, input logic b_zero,
                                       input logic or_equal);
        logic lt;
        logic eq;
        if (a_zero && b_zero) begin
            lt = 1'b0;
            eq = 1'b1;
        end else if (a_sign != b_sign) begin
            lt = a_sign;
            eq = 1'b0;
        end else if (a_sign) begin
            lt = !mag_lt && !mag_eq;
            eq = mag_eq;
        end else begin
            lt = mag_lt;
            eq = mag_eq;
        end
        return lt || (or_equal && eq);
    endfunction

endpackage

// File: rtl/fp_bound_lane.sv
// rtl/fp_bound_lane.sv - one lane of stage-1 compare flags; FP_BOUND_NAN_EN adds the NaN flag
module fp_bound_lane
    import fp_bound_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] a_in,
    input  logic [EXP_W+MAN_W:0] b_in,
    output logic                 mag_lt_out,
    output logic                 mag_eq_out,
    output logic                 a_sign_out,
    output logic                 b_sign_out,
    output logic                 a_zero_out,
    output logic                 b_zero_out
`ifdef FP_BOUND_NAN_EN
    ,
    output logic                 nan_out
`endif
);

    localparam int W = fp_w(EXP_W, MAN_W);

    logic [W-2:0] a_mag;
    logic [W-2:0] b_mag;

    always_comb begin
        a_mag      = a_in[W-2:0];
        b_mag      = b_in[W-2:0];
        mag_lt_out = a_mag < b_mag;
        mag_eq_out = a_mag == b_mag;
        a_sign_out = a_in[W-1];
        b_sign_out = b_in[W-1];
        a_zero_out = is_zero(64'(a_in), EXP_W, MAN_W);
        b_zero_out = is_zero(64'(b_in), EXP_W, MAN_W);
`ifdef FP_BOUND_NAN_EN
        nan_out    = is_nan(64'(a_in), EXP_W, MAN_W) || is_nan(64'(b_in), EXP_W, MAN_W);
`endif
    end

endmodule

// File: rtl/fp_bound_vec.sv
// rtl/fp_bound_vec.sv - two-stage multi-lane float bound comparator; FP_BOUND_NAN_EN adds nan_out
module fp_bound_vec
    import fp_bound_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int EXP_W    = 8,
    parameter int MAN_W    = 23,
    parameter int TAG_W    = 4
) (
    input  logic                                 clk_in,
    input  logic                                 rst_n_in,
    input  logic                                 valid_in,
    output logic                                 ready_out,
    input  logic [1:0]                           mode_in,
    input  logic [TAG_W-1:0]                     tag_in,
    input  logic [CHANNELS-1:0][EXP_W+MAN_W:0]   a_in,
    input  logic [CHANNELS-1:0][EXP_W+MAN_W:0]   b_in,
    output logic                                 valid_out,
    input  logic                                 ready_in,
    output logic [CHANNELS-1:0]                  c_out,
    output logic                                 all_out,
    output logic                                 any_out,
    output logic [TAG_W-1:0]                     tag_out
`ifdef FP_BOUND_NAN_EN
    ,
    output logic [CHANNELS-1:0]                  nan_out
`endif
);

    logic [CHANNELS-1:0] lt_w, eq_w, sa_w, sb_w, za_w, zb_w;
    logic [CHANNELS-1:0] s1_lt_q, s1_eq_q, s1_sa_q, s1_sb_q, s1_za_q, s1_zb_q;
    logic [CHANNELS-1:0] s1_lt_d, s1_eq_d, s1_sa_d, s1_sb_d, s1_za_d, s1_zb_d;
    mode_t               s1_mode_q, s1_mode_d;
    logic [TAG_W-1:0]    s1_tag_q, s1_tag_d;
    logic                s1_v_q, s1_v_d;

    logic [CHANNELS-1:0] c_w;
    logic [CHANNELS-1:0] c_q, c_d;
    logic                all_q, all_d, any_q, any_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic                s2_v_q, s2_v_d;

`ifdef FP_BOUND_NAN_EN
    logic [CHANNELS-1:0] nan_w, s1_nan_q, s1_nan_d, nan_q, nan_d;
`endif

    logic s1_load;
    logic s2_load;

    assign ready_out = !s1_v_q || !s2_v_q || ready_in;
    assign s1_load   = valid_in && ready_out;
    assign s2_load   = s1_v_q && (!s2_v_q || ready_in);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        fp_bound_lane #(
            .EXP_W (EXP_W),
            .MAN_W (MAN_W)
        ) u_lane (
            .a_in       (a_in[i]),
            .b_in       (b_in[i]),
            .mag_lt_out (lt_w[i]),
            .mag_eq_out (eq_w[i]),
            .a_sign_out (sa_w[i]),
            .b_sign_out (sb_w[i]),
            .a_zero_out (za_w[i]),
            .b_zero_out (zb_w[i])
`ifdef FP_BOUND_NAN_EN
            ,
            .nan_out    (nan_w[i])
`endif
        );
    end

    always_comb begin
        c_w = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            case (s1_mode_q)
                ABS_LE:  c_w[i] = s1_lt_q[i] || s1_eq_q[i];
                ABS_LT:  c_w[i] = s1_lt_q[i];
                SGN_LE:  c_w[i] = sgn_order(s1_lt_q[i], s1_eq_q[i], s1_sa_q[i], s1_sb_q[i],
                                            s1_za_q[i], s1_zb_q[i], 1'b1);
                default: c_w[i] = sgn_order(s1_lt_q[i], s1_eq_q[i], s1_sa_q[i], s1_sb_q[i],
                                            s1_za_q[i], s1_zb_q[i], 1'b0);
            endcase
`ifdef FP_BOUND_NAN_EN
            if (s1_nan_q[i]) begin
                c_w[i] = 1'b0;
            end
`endif
        end
    end

    always_comb begin
        s1_lt_d   = s1_load ? lt_w : s1_lt_q;
        s1_eq_d   = s1_load ? eq_w : s1_eq_q;
        s1_sa_d   = s1_load ? sa_w : s1_sa_q;
        s1_sb_d   = s1_load ? sb_w : s1_sb_q;
        s1_za_d   = s1_load ? za_w : s1_za_q;
        s1_zb_d   = s1_load ? zb_w : s1_zb_q;
        s1_mode_d = s1_load ? mode_t'(mode_in) : s1_mode_q;
        s1_tag_d  = s1_load ? tag_in : s1_tag_q;
        // A beat leaving S1 is replaced only if a new one arrives on the same edge.
        s1_v_d    = s1_load ? 1'b1 : (s2_load ? 1'b0 : s1_v_q);

        c_d       = s2_load ? c_w : c_q;
        all_d     = s2_load ? (&c_w) : all_q;
        any_d     = s2_load ? (|c_w) : any_q;
        tag_d     = s2_load ? s1_tag_q : tag_q;
        s2_v_d    = s2_load ? 1'b1 : (ready_in ? 1'b0 : s2_v_q);
`ifdef FP_BOUND_NAN_EN
        s1_nan_d  = s1_load ? nan_w : s1_nan_q;
        nan_d     = s2_load ? s1_nan_q : nan_q;
`endif
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_lt_q   <= '0;
            s1_eq_q   <= '0;
            s1_sa_q   <= '0;
            s1_sb_q   <= '0;
            s1_za_q   <= '0;
            s1_zb_q   <= '0;
            s1_mode_q <= ABS_LE;
            s1_tag_q  <= '0;
            s1_v_q    <= 1'b0;
            c_q       <= '0;
            all_q     <= 1'b0;
            any_q     <= 1'b0;
            tag_q     <= '0;
            s2_v_q    <= 1'b0;
`ifdef FP_BOUND_NAN_EN
            s1_nan_q  <= '0;
            nan_q     <= '0;
`endif
        end else begin
            s1_lt_q   <= s1_lt_d;
            s1_eq_q   <= s1_eq_d;
            s1_sa_q   <= s1_sa_d;
            s1_sb_q   <= s1_sb_d;
            s1_za_q   <= s1_za_d;
            s1_zb_q   <= s1_zb_d;
            s1_mode_q <= s1_mode_d;
            s1_tag_q  <= s1_tag_d;
            s1_v_q    <= s1_v_d;
            c_q       <= c_d;
            all_q     <= all_d;
            any_q     <= any_d;
            tag_q     <= tag_d;
            s2_v_q    <= s2_v_d;
`ifdef FP_BOUND_NAN_EN
            s1_nan_q  <= s1_nan_d;
            nan_q     <= nan_d;
`endif
        end
    end

    assign valid_out = s2_v_q;
    assign c_out     = c_q;
    assign all_out   = all_q;
    assign any_out   = any_q;
    assign tag_out   = tag_q;
`ifdef FP_BOUND_NAN_EN
    assign nan_out   = nan_q;
`endif

endmodule

// File: tb/tb_fp_bound_vec.sv
// tb/tb_fp_bound_vec.sv - directed vector bench for fp_bound_vec (handles FP_BOUND_NAN_EN builds)
module tb_fp_bound_vec;
    import fp_bound_pkg::*;

    localparam int CH = 4;
    localparam int TW = 4;
    localparam int NV = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n, valid_in, ready_out, valid_out, ready_in, all_out, any_out;
    logic [1:0]           mode_in;
    logic [TW-1:0]        tag_in, tag_out;
    logic [CH-1:0][31:0]  a_in, b_in;
    logic [CH-1:0]        c_out;
`ifdef FP_BOUND_NAN_EN
    logic [CH-1:0]        nan_out;
`endif

    fp_bound_vec #(.CHANNELS(CH), .EXP_W(8), .MAN_W(23), .TAG_W(TW)) dut (
        .clk_in    (clk),
        .rst_n_in  (rst_n),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .mode_in   (mode_in),
        .tag_in    (tag_in),
        .a_in      (a_in),
        .b_in      (b_in),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .c_out     (c_out),
        .all_out   (all_out),
        .any_out   (any_out),
        .tag_out   (tag_out)
`ifdef FP_BOUND_NAN_EN
        ,
        .nan_out   (nan_out)
`endif
    );

    typedef struct packed {
        logic [1:0]   mode;
        logic [127:0] a;
        logic [127:0] b;
        logic [3:0]   c;
        logic         all_v;
        logic         any_v;
        logic [3:0]   nan;
    } vec_t;

    vec_t vecs [NV];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] m, input logic [127:0] a, input logic [127:0] b,
                                input logic [3:0] c, input logic al, input logic an,
                                input logic [3:0] nan);
        vec_t v;
        v.mode = m; v.a = a; v.b = b; v.c = c; v.all_v = al; v.any_v = an; v.nan = nan;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] a0, b0;
        logic [3:0]   exp_by_mode [4];
        int           sent, rcvd, low_cyc;
        logic         stalled_prev, do_acc;
        logic [3:0]   held_c;
        logic [TW-1:0] held_tag;

        // Lanes (l3..l0): 2 vs 2, -0 vs +0, 1 vs -2, -2 vs 1
        a0 = {32'h40000000, 32'h80000000, 32'h3F800000, 32'hC0000000};
        b0 = {32'h40000000, 32'h00000000, 32'hC0000000, 32'h3F800000};
        vecs[0]  = mk(2'd0, a0, b0, 4'b1110, 1'b0, 1'b1, 4'b0000);
        vecs[1]  = mk(2'd2, a0, b0, 4'b1101, 1'b0, 1'b1, 4'b0000);
        vecs[2]  = mk(2'd3, a0, b0, 4'b0001, 1'b0, 1'b1, 4'b0000);
        vecs[3]  = mk(2'd1, a0, b0, 4'b0010, 1'b0, 1'b1, 4'b0000);
        vecs[4]  = mk(2'd2, {32'h00000000, 32'hBF800000, 32'h40000000, 32'h3F800000},
                            {32'h00000000, 32'h3F800000, 32'h3F800000, 32'h40000000},
                      4'b1101, 1'b0, 1'b1, 4'b0000);
        vecs[5]  = mk(2'd2, {32'h00000000, 32'hBF800000, 32'hC0000000, 32'hBF800000},
                            {32'h80000000, 32'hBF800000, 32'hBF800000, 32'hC0000000},
                      4'b1110, 1'b0, 1'b1, 4'b0000);
        vecs[6]  = mk(2'd3, {32'h00000000, 32'hBF800000, 32'hC0000000, 32'hBF800000},
                            {32'h80000000, 32'hBF800000, 32'hBF800000, 32'hC0000000},
                      4'b0010, 1'b0, 1'b1, 4'b0000);
        vecs[7]  = mk(2'd2, {32'h80000000, 32'h7F7FFFFF, 32'hFF800000, 32'h7F800000},
                            {32'hC0A00000, 32'h7F800000, 32'hFF7FFFFF, 32'h7F7FFFFF},
                      4'b0110, 1'b0, 1'b1, 4'b0000);
        vecs[8]  = mk(2'd0, {4{32'h3F800000}}, {4{32'h40000000}}, 4'b1111, 1'b1, 1'b1, 4'b0000);
        vecs[9]  = mk(2'd0, {4{32'h7FC00000}}, {4{32'h7F800000}}, 4'b0000, 1'b0, 1'b0, 4'b1111);
        vecs[10] = mk(2'd3, {32'hBF800000, 32'h40000000, 32'h3F800000, 32'h7FC00000},
                            {32'h3F800000, 32'h3F800000, 32'h40000000, 32'h7F800000},
                      4'b1010, 1'b0, 1'b1, 4'b0001);
        vecs[11] = mk(2'd2, {4{32'h7FC00000}}, {4{32'h7F800000}}, 4'b0000, 1'b0, 1'b0, 4'b1111);
        exp_by_mode[0] = 4'b1110;
        exp_by_mode[1] = 4'b0010;
        exp_by_mode[2] = 4'b1101;
        exp_by_mode[3] = 4'b0001;

        rst_n = 1'b0; valid_in = 1'b0; ready_in = 1'b1; mode_in = 2'd0; tag_in = '0;
        a_in = '0; b_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_ready_out", 32'(ready_out), 32'd1);
        chk("rst_c_out", 32'(c_out), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            valid_in = 1'b1; mode_in = vecs[i].mode; tag_in = 4'(i);
            a_in = vecs[i].a; b_in = vecs[i].b; ready_in = 1'b1;
            #4;
            chk($sformatf("v%0d_ready", i), 32'(ready_out), 32'd1);
            @(posedge clk); #1;
            valid_in = 1'b0;
            chk($sformatf("v%0d_lat1_valid", i), 32'(valid_out), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", i), 32'(valid_out), 32'd1);
            chk($sformatf("v%0d_c", i), 32'(c_out), 32'(vecs[i].c));
            chk($sformatf("v%0d_all", i), 32'(all_out), 32'(vecs[i].all_v));
            chk($sformatf("v%0d_any", i), 32'(any_out), 32'(vecs[i].any_v));
            chk($sformatf("v%0d_tag", i), 32'(tag_out), i);
`ifdef FP_BOUND_NAN_EN
            chk($sformatf("v%0d_nan", i), 32'(nan_out), 32'(vecs[i].nan));
`endif
        end

        // Backpressure: 8 beats, mode follows tag, ready_in low in cycles 3..6
        sent = 0; rcvd = 0; low_cyc = 0; stalled_prev = 1'b0; held_c = '0; held_tag = '0;
        a_in = a0; b_in = b0;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 40 && rcvd < 8; cyc++) begin
            ready_in = !(cyc >= 3 && cyc <= 6);
            valid_in = (sent < 8);
            tag_in   = sent[3:0];
            mode_in  = sent[1:0];
            #4;
            if (!ready_out) low_cyc++;
            if (valid_out && stalled_prev) begin
                chk("stall_tag", 32'(tag_out), 32'(held_tag));
                chk("stall_c", 32'(c_out), 32'(held_c));
            end
            if (valid_out && ready_in) begin
                chk("bp_tag", 32'(tag_out), rcvd);
                chk("bp_c", 32'(c_out), 32'(exp_by_mode[rcvd % 4]));
                rcvd++;
            end
            stalled_prev = valid_out && !ready_in;
            held_tag = tag_out;
            held_c = c_out;
            do_acc = valid_in && ready_out;
            @(posedge clk); #1;
            if (do_acc) sent++;
        end
        valid_in = 1'b0;
        chk("bp_received", rcvd, 32'd8);
        chk("bp_ready_low_cycles", low_cyc, 32'd4);

        // Reset mid-stall with both stages full
        ready_in = 1'b0;
        a_in = vecs[8].a; b_in = vecs[8].b; mode_in = 2'd0;
        @(posedge clk); #1;
        valid_in = 1'b1; tag_in = 4'hF;
        @(posedge clk); #1;
        tag_in = 4'hE;
        @(posedge clk); #1;
        valid_in = 1'b0;
        chk("full_valid_out", 32'(valid_out), 32'd1);
        chk("full_ready_out", 32'(ready_out), 32'd0);
        chk("full_c", 32'(c_out), 32'hF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid_out", 32'(valid_out), 32'd0);
        chk("arst_c", 32'(c_out), 32'd0);
        chk("arst_all", 32'(all_out), 32'd0);
        chk("arst_any", 32'(any_out), 32'd0);
        chk("arst_tag", 32'(tag_out), 32'd0);
        chk("arst_ready_out", 32'(ready_out), 32'd1);
`ifdef FP_BOUND_NAN_EN
        chk("arst_nan", 32'(nan_out), 32'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1; ready_in = 1'b1;
        valid_in = 1'b1; mode_in = 2'd2; tag_in = 4'h3; a_in = a0; b_in = b0;
        @(posedge clk); #1;
        valid_in = 1'b0;
        chk("post_rst_no_stale", 32'(valid_out), 32'd0);
        @(posedge clk); #1;
        chk("post_rst_valid", 32'(valid_out), 32'd1);
        chk("post_rst_tag", 32'(tag_out), 32'd3);
        chk("post_rst_c", 32'(c_out), 32'b1101);
        @(posedge clk); #1;
        chk("post_rst_drain", 32'(valid_out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
